// File: rtl/uart_tx_ctrl_if.sv
// UART TX frame controller bus: parallel word, parity handshake and serial line.
// Latency: none (signal bundle only).
// Backpressure: none; the busy level tells the sender when a word will be accepted.
// Ports: p_data/data_valid/par_en/par_bit go into the serializer; tx_out/busy come out of it.
interface uart_tx_ctrl_if #(
  parameter int data_width = 8
);
  logic [data_width-1:0] p_data;
  logic                  data_valid;
  logic                  par_en;
  logic                  par_bit;
  logic                  tx_out;
  logic                  busy;

  // master: the system side plus the parity calculator
  modport master (
    output p_data, data_valid, par_en, par_bit,
    input  tx_out, busy
  );

  // slave: the frame serializer
  modport slave (
    input  p_data, data_valid, par_en, par_bit,
    output tx_out, busy
  );
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART TX frame controller: serializes start, data (LSB first), optional parity, stop.
// Latency: start bit appears the cycle after acceptance; frame lasts 2+data_width+par_en cycles.
// Backpressure: data_valid is honoured only while busy=0; words offered mid-frame are dropped.
// Ports: clk (one bit per cycle), rst (sync active-low), bus (uart_tx_ctrl_if.slave).
module uart_tx_ctrl #(
  parameter int data_width = 8
) (
  input  logic            clk,
  input  logic            rst,
  uart_tx_ctrl_if.slave   bus
);

  localparam int cnt_w = (data_width > 1) ? $clog2(data_width) : 1;
  localparam logic [cnt_w-1:0] last_cnt = cnt_w'(data_width - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [data_width-1:0] shreg_q, shreg_d;
  logic [cnt_w-1:0]      cnt_q, cnt_d;
  logic                  par_en_q, par_en_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      cnt_q    <= '0;
      par_en_q <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
      par_en_q <= par_en_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
    end
  end

  // tx_d/busy_d describe the line during the state being entered, so the
  // registered outputs line up exactly with the state register.
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    par_en_d = par_en_q;
    tx_d     = 1'b1;
    busy_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.data_valid) begin
          state_d  = START;
          shreg_d  = bus.p_data;
          par_en_d = bus.par_en;
          tx_d     = 1'b0;
          busy_d   = 1'b1;
        end
      end

      START: begin
        state_d = DATA;
        cnt_d   = '0;
        tx_d    = shreg_q[0];
        shreg_d = shreg_q >> 1;
        busy_d  = 1'b1;
      end

      DATA: begin
        busy_d = 1'b1;
        if (cnt_q == last_cnt) begin
          // par_bit is captured here, at the edge that enters PARITY
          if (par_en_q) begin
            state_d = PARITY;
            tx_d    = bus.par_bit;
          end else begin
            state_d = STOP;
            tx_d    = 1'b1;
          end
        end else begin
          cnt_d   = cnt_q + 1'b1;
          tx_d    = shreg_q[0];
          shreg_d = shreg_q >> 1;
        end
      end

      PARITY: begin
        state_d = STOP;
        tx_d    = 1'b1;
        busy_d  = 1'b1;
      end

      STOP: begin
        // data_valid is ignored here; the next acceptance is one IDLE cycle later
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.tx_out = tx_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: directed frames with literal expectations plus random traffic.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_tx_ctrl;
  localparam int dw = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_tx_ctrl_if #(.data_width(dw)) bf();

  uart_tx_ctrl #(.data_width(dw)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bf.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Parity calculator stand-in: relatches the word whenever busy is low.
  logic [dw-1:0] calc_q = '0;
  logic          par_odd;
  always @(posedge clk) if (bf.busy !== 1'b1) calc_q <= bf.p_data;
  assign bf.par_bit = (^calc_q) ^ par_odd;

  // Reference model: a frame is a queue of line values; 2 marks "par_bit at this edge".
  int   q[$];
  logic exp_tx   = 1'b1;
  logic exp_busy = 1'b0;
  bit   model_on = 1'b0;

  always @(posedge clk) begin
    int v;
    if (!rst) begin
      q.delete();
      exp_tx   = 1'b1;
      exp_busy = 1'b0;
    end else begin
      if (!exp_busy && bf.data_valid) begin
        q.push_back(0);
        for (int i = 0; i < dw; i++) q.push_back(int'(bf.p_data[i]));
        if (bf.par_en) q.push_back(2);
        q.push_back(1);
      end
      if (q.size() != 0) begin
        v        = q.pop_front();
        exp_tx   = (v == 2) ? bf.par_bit : v[0];
        exp_busy = 1'b1;
      end else begin
        exp_tx   = 1'b1;
        exp_busy = 1'b0;
      end
    end
    model_on = 1'b1;
  end

  always @(negedge clk) begin
    if (model_on) begin
      check("model_tx_out", 32'(bf.tx_out), 32'(exp_tx));
      check("model_busy",   32'(bf.busy),   32'(exp_busy));
    end
  end

  // Offer one word for a single edge; returns at the negedge after acceptance.
  task automatic send(input logic [dw-1:0] d, input logic pe, input logic odd);
    bf.p_data     = d;
    bf.par_en     = pe;
    par_odd       = odd;
    bf.data_valid = 1'b1;
    @(negedge clk);
    bf.data_valid = 1'b0;
  endtask

  // Record tx_out while busy is high (bounded); ends on the first idle negedge.
  task automatic frame_watch(output logic [31:0] bits, output int n);
    bits = '0;
    n    = 0;
    while (bf.busy === 1'b1 && n < 40) begin
      bits[n] = bf.tx_out;
      n++;
      @(negedge clk);
    end
  endtask

  logic [31:0] bits;
  int          n;

  initial begin
    rst           = 1'b0;
    bf.data_valid = 1'b1;
    bf.p_data     = 8'hA5;
    bf.par_en     = 1'b0;
    par_odd       = 1'b0;

    // reset held with data_valid high: line stays idle
    repeat (3) begin
      @(negedge clk);
      check("rst_tx_out", 32'(bf.tx_out), 32'd1);
      check("rst_busy",   32'(bf.busy),   32'd0);
    end
    rst           = 1'b1;
    bf.data_valid = 1'b0;
    @(negedge clk);
    check("idle_busy", 32'(bf.busy), 32'd0);

    // 0xA5 no parity: 0,1,0,1,0,0,1,0,1,1
    send(8'hA5, 1'b0, 1'b0);
    frame_watch(bits, n);
    check("nopar_bits", bits, 32'h34A);
    check("nopar_len",  32'(n), 32'd10);
    check("nopar_idle_tx", 32'(bf.tx_out), 32'd1);

    // 0xA5 even parity: 0,1,0,1,0,0,1,0,1,0,1
    send(8'hA5, 1'b1, 1'b0);
    frame_watch(bits, n);
    check("even_bits", bits, 32'h54A);
    check("even_len",  32'(n), 32'd11);

    // 0x01 odd parity (par_bit=0): 0,1,0,0,0,0,0,0,0,0,1
    send(8'h01, 1'b1, 1'b1);
    frame_watch(bits, n);
    check("odd_bits", bits, 32'h402);
    check("odd_len",  32'(n), 32'd11);

    // data_valid held: 0x3C, change to 0xFF mid-frame, one idle gap, then 0xFF
    bf.p_data     = 8'h3C;
    bf.par_en     = 1'b0;
    par_odd       = 1'b0;
    bf.data_valid = 1'b1;
    @(negedge clk);
    bf.p_data = 8'hFF;
    frame_watch(bits, n);
    check("b2b_first_bits", bits, 32'h278);
    check("b2b_first_len",  32'(n), 32'd10);
    check("b2b_gap_busy",   32'(bf.busy),   32'd0);
    check("b2b_gap_tx",     32'(bf.tx_out), 32'd1);
    @(negedge clk);
    bf.data_valid = 1'b0;
    check("b2b_restart_busy", 32'(bf.busy), 32'd1);
    frame_watch(bits, n);
    check("b2b_second_bits", bits, 32'h3FE);
    check("b2b_second_len",  32'(n), 32'd10);

    // reset during data bit 3 abandons the frame
    send(8'h77, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    check("mid_bit3", 32'(bf.tx_out), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_tx",   32'(bf.tx_out), 32'd1);
    check("mid_rst_busy", 32'(bf.busy),   32'd0);
    rst = 1'b1;
    @(negedge clk);
    // 0x5A even parity: 0,0,1,0,1,1,0,1,0,0,1
    send(8'h5A, 1'b1, 1'b0);
    frame_watch(bits, n);
    check("post_rst_bits", bits, 32'h4B4);
    check("post_rst_len",  32'(n), 32'd11);

    // random traffic, occasional resets; the model checks every cycle
    repeat (3000) begin
      if (bf.busy !== 1'b1) begin
        bf.par_en = 1'($urandom);
        par_odd   = 1'($urandom);
      end
      bf.p_data     = 8'($urandom);
      bf.data_valid = ($urandom_range(0, 2) == 0);
      rst           = ($urandom_range(0, 199) != 0);
      @(negedge clk);
    end
    rst           = 1'b1;
    bf.data_valid = 1'b0;
    repeat (30) @(negedge clk);
    check("final_idle_busy", 32'(bf.busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
